fwd_select_unit: RTL and testbench

//  Operand-forwarding control for the 16-bit pipelined datapath. Tracks the destination registers of

---
 rtl/fwd_select_unit_pkg.sv | 15 +
 rtl/fwd_select_unit_src_sel.sv | 41 ++++
 rtl/fwd_select_unit.sv | 113 +++++++++++
 tb/tb_fwd_select_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_select_unit_pkg.sv
// Shared definitions for the operand-forwarding unit: EX operand-mux select
// encoding and default widths.
package fwd_select_unit_pkg;

   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10,
      SEL_IMM = 2'b11
   } fwd_sel_e;

   localparam int DEF_REG_AW = 4;
   localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/fwd_select_unit_src_sel.sv
// Per-operand forwarding decision: compares one ID source register against the
// EX and MEM destination entries and reports the mux select and load-use condition.
module fwd_select_unit_src_sel
   import fwd_select_unit_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic [REG_AW-1:0] src,
   input  logic              ex_v,
   input  logic              ex_wr,
   input  logic              ex_ld,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_v,
   input  logic              mem_wr,
   input  logic [REG_AW-1:0] mem_rd,
   output fwd_sel_e          sel,
   output logic              load_use
);

   logic src_nonzero;
   logic ex_match;
   logic mem_match;

   // R0 reads as zero in the regfile, so a write to it must never be forwarded.
   assign src_nonzero = (src != '0);
   assign ex_match    = ex_v  & ex_wr  & (ex_rd  == src) & src_nonzero;
   assign mem_match   = mem_v & mem_wr & (mem_rd == src) & src_nonzero;

   // The younger producer (EX) takes priority over the older one (MEM).
   always_comb begin
      sel = SEL_REG;
      if (ex_match) begin
         sel = SEL_MEM;
      end else if (mem_match) begin
         sel = SEL_WB;
      end
   end

   assign load_use = ex_match & ex_ld;

endmodule

// File: rtl/fwd_select_unit.sv
// Operand-forwarding control: tracks EX/MEM destinations, registers the EX operand
// mux selects, detects load-use hazards and counts the bubbles they cause.
module fwd_select_unit
   import fwd_select_unit_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_imm,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              hazard,
   output logic [CNT_W-1:0]  hazard_cnt
);

   logic              ex_v;
   logic              ex_wr;
   logic              ex_ld;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_v;
   logic              mem_wr;
   logic [REG_AW-1:0] mem_rd;

   fwd_sel_e src_sel_a;
   fwd_sel_e src_sel_b;
   logic     load_use_a;
   logic     load_use_b;
   logic     issue;

   fwd_select_unit_src_sel #(.REG_AW(REG_AW)) u_sel_a (
      .src      (id_rs),
      .ex_v     (ex_v),
      .ex_wr    (ex_wr),
      .ex_ld    (ex_ld),
      .ex_rd    (ex_rd),
      .mem_v    (mem_v),
      .mem_wr   (mem_wr),
      .mem_rd   (mem_rd),
      .sel      (src_sel_a),
      .load_use (load_use_a)
   );

   fwd_select_unit_src_sel #(.REG_AW(REG_AW)) u_sel_b (
      .src      (id_rt),
      .ex_v     (ex_v),
      .ex_wr    (ex_wr),
      .ex_ld    (ex_ld),
      .ex_rd    (ex_rd),
      .mem_v    (mem_v),
      .mem_wr   (mem_wr),
      .mem_rd   (mem_rd),
      .sel      (src_sel_b),
      .load_use (load_use_b)
   );

   // Operand B only depends on a register when it is not taking the immediate.
   assign hazard = id_valid & (load_use_a | (~id_use_imm & load_use_b));
   assign issue  = id_valid & ~flush & ~hazard;

   // The MEM entry never needs its load flag: a load in MEM is forwarded from WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_v   <= 1'b0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         ex_rd  <= '0;
         mem_v  <= 1'b0;
         mem_wr <= 1'b0;
         mem_rd <= '0;
         sel_a  <= SEL_REG;
         sel_b  <= SEL_REG;
      end else if (!stall) begin
         mem_v  <= ex_v;
         mem_wr <= ex_wr;
         mem_rd <= ex_rd;
         if (issue) begin
            ex_v  <= 1'b1;
            ex_wr <= id_wr_en;
            ex_ld <= id_is_load;
            ex_rd <= id_rd;
            sel_a <= src_sel_a;
            sel_b <= id_use_imm ? SEL_IMM : src_sel_b;
         end else begin
            ex_v  <= 1'b0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
            ex_rd <= '0;
            sel_a <= SEL_REG;
            sel_b <= SEL_REG;
         end
      end
   end

   // A flushed instruction would have been discarded anyway, so its bubble is not charged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_cnt <= '0;
      end else if (!stall && hazard && !flush && (hazard_cnt != '1)) begin
         hazard_cnt <= hazard_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_select_unit.sv
// Self-checking bench for fwd_select_unit: vector table with a select scoreboard,
// plus hand-written reset, stall and counter-saturation sequences.
module tb_fwd_select_unit;

   localparam int REG_AW = 4;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic              id_wr_en;
   logic              id_is_load;
   logic [REG_AW-1:0] id_rd;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_imm;
   logic [1:0]        sel_a;
   logic [1:0]        sel_b;
   logic              hazard;
   logic [CNT_W-1:0]  hazard_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       stl;
      logic       fl;
      logic       v;
      logic       wr;
      logic       ld;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       imm;
      logic       haz;
      logic [1:0] a;
      logic [1:0] b;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] sb_q[$];

   always #5 clk = ~clk;

   fwd_select_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_wr_en   (id_wr_en),
      .id_is_load (id_is_load),
      .id_rd      (id_rd),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_imm (id_use_imm),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .hazard     (hazard),
      .hazard_cnt (hazard_cnt)
   );

   function automatic vec_t mk(input logic stl, input logic fl, input logic v,
                               input logic wr, input logic ld, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt, input logic imm,
                               input logic haz, input logic [1:0] a, input logic [1:0] b);
      vec_t t;
      t.stl = stl; t.fl = fl; t.v = v; t.wr = wr; t.ld = ld;
      t.rd = rd; t.rs = rs; t.rt = rt; t.imm = imm;
      t.haz = haz; t.a = a; t.b = b;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      stall      = t.stl;
      flush      = t.fl;
      id_valid   = t.v;
      id_wr_en   = t.wr;
      id_is_load = t.ld;
      id_rd      = t.rd;
      id_rs      = t.rs;
      id_rt      = t.rt;
      id_use_imm = t.imm;
   endtask

   // Pops the selects expected for the instruction that just crossed the edge.
   task automatic checkOutput(input string tag);
      logic [3:0] exp;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         exp = sb_q.pop_front();
         check({tag, "_sel_a"}, 32'(sel_a), 32'(exp[3:2]));
         check({tag, "_sel_b"}, 32'(sel_b), 32'(exp[1:0]));
      end
   endtask

   task automatic applyStimulus(input vec_t t, input string tag);
      @(negedge clk);
      drive(t);
      #1;
      check({tag, "_hazard"}, 32'(hazard), 32'(t.haz));
      sb_q.push_back({t.a, t.b});
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0,0, 0,0,0, 0, 0, 2'd0, 2'd0);
      rst_n = 1'b0;
      drive(idle);

      //        stl fl v wr ld  rd  rs  rt imm haz  a  b
      tbl.push_back(mk(0,0,1,1,0,  3,  1,  2, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  4,  3,  0, 0, 0, 1, 0));
      tbl.push_back(mk(0,0,1,1,0,  6,  1,  1, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,0,0,0,  0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  7,  6,  4, 0, 0, 2, 0));
      tbl.push_back(mk(0,0,1,1,0,  5,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  5,  7,  0, 0, 0, 2, 0));
      tbl.push_back(mk(0,0,1,1,0,  8,  1,  5, 0, 0, 0, 1));
      tbl.push_back(mk(0,0,1,1,0,  5,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  5,  0,  8, 0, 0, 0, 2));
      tbl.push_back(mk(0,0,1,1,0,  9,  5,  5, 1, 0, 1, 3));
      tbl.push_back(mk(0,0,1,1,1,  2,  9,  0, 0, 0, 1, 0));
      tbl.push_back(mk(0,0,1,1,0, 10,  2,  0, 0, 1, 0, 0));
      tbl.push_back(mk(0,0,1,1,0, 10,  2,  0, 0, 0, 2, 0));
      tbl.push_back(mk(0,0,1,1,1,  0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0, 11,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0, 12, 11, 10, 1, 0, 1, 3));
      tbl.push_back(mk(1,0,1,1,0, 13, 12, 11, 0, 0, 1, 3));
      tbl.push_back(mk(1,0,1,1,0, 13, 12, 11, 0, 0, 1, 3));
      tbl.push_back(mk(1,0,1,1,0, 13, 12, 11, 0, 0, 1, 3));
      tbl.push_back(mk(0,0,1,1,0, 13, 12, 11, 0, 0, 1, 2));
      tbl.push_back(mk(0,1,1,1,0, 14, 13, 12, 0, 0, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  1, 13, 13, 0, 0, 2, 2));
      tbl.push_back(mk(0,0,1,1,0,  2, 14,  1, 0, 0, 0, 1));
      tbl.push_back(mk(0,0,1,1,1,  3,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,1,1,0,  4,  3,  0, 0, 1, 0, 0));
      tbl.push_back(mk(0,0,1,1,0,  4,  3,  3, 0, 0, 2, 2));

      #12;
      check("reset_sel_a", 32'(sel_a), 32'd0);
      check("reset_sel_b", 32'(sel_b), 32'd0);
      check("reset_hazard", 32'(hazard), 32'd0);
      check("reset_cnt", 32'(hazard_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i], $sformatf("vec%0d", i));
      end
      check("cnt_after_table", 32'(hazard_cnt), 32'd1);

      // Asynchronous reset with live EX/MEM entries and a pending load-use.
      applyStimulus(mk(0,0,1,1,1, 6, 4, 0, 0, 0, 2'd1, 2'd0), "ld_before_rst");
      @(negedge clk);
      drive(mk(0,0,1,1,0, 7, 6, 6, 0, 0, 2'd0, 2'd0));
      #1;
      check("pre_rst_hazard", 32'(hazard), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_sel_a", 32'(sel_a), 32'd0);
      check("rst_mid_sel_b", 32'(sel_b), 32'd0);
      check("rst_mid_hazard", 32'(hazard), 32'd0);
      check("rst_mid_cnt", 32'(hazard_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk(0,0,1,1,0, 7, 6, 6, 0, 0, 2'd0, 2'd0), "post_rst");

      // A stalled load-use raises hazard but must not be counted.
      applyStimulus(mk(0,0,1,1,1, 2, 0, 0, 0, 0, 2'd0, 2'd0), "stall_ld");
      applyStimulus(mk(1,0,1,1,0, 3, 2, 0, 0, 1, 2'd0, 2'd0), "stall_haz");
      check("stall_no_count", 32'(hazard_cnt), 32'd0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(mk(0,0,1,1,1, 2, 0, 0, 0, 0, 2'd0, 2'd0), $sformatf("sat_ld%0d", i));
         applyStimulus(mk(0,0,1,1,0, 3, 2, 0, 0, 1, 2'd0, 2'd0), $sformatf("sat_use%0d", i));
         check($sformatf("sat_cnt%0d", i), 32'(hazard_cnt),
               (i + 1 < 31) ? 32'(i + 1) : 32'd31);
      end

      applyStimulus(mk(0,0,1,1,1, 2, 0, 0, 0, 0, 2'd0, 2'd0), "flush_ld");
      applyStimulus(mk(0,1,1,1,0, 3, 2, 0, 0, 1, 2'd0, 2'd0), "flush_haz");
      check("cnt_saturated", 32'(hazard_cnt), 32'd31);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
